// File: rtl/motion_cmd_sequencer.sv
// Motion command sequencer.
// Decodes SPI command frames into segment FIFO writes, motion/spindle/coolant
// control levels and a per-cycle status byte for the next SPI transfer.
module motion_cmd_sequencer #(
    parameter int unsigned NUM_AXES       = 3,
    parameter int unsigned STEP_WIDTH     = 32,
    parameter int unsigned VELOCITY_WIDTH = 24
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [7:0]                                    rx_data,
    input  logic                                          rx_valid,
    input  logic                                          spi_cs_n,
    output logic [7:0]                                    tx_data,
    output logic                                          seg_wr,
    output logic [NUM_AXES*STEP_WIDTH+4*VELOCITY_WIDTH-1:0] seg_data,
    input  logic                                          fifo_full,
    output logic                                          fifo_flush,
    input  logic                                          step_busy,
    input  logic [NUM_AXES-1:0]                           limit_hit,
    output logic                                          motion_enable,
    output logic                                          spindle_en,
    output logic                                          spindle_dir,
    output logic                                          coolant_mist,
    output logic                                          coolant_flood,
    output logic [15:0]                                   spindle_duty
);

    localparam int unsigned POS_BITS = NUM_AXES * STEP_WIDTH;
    localparam int unsigned SEG_W    = POS_BITS + 4 * VELOCITY_WIDTH;
    localparam int unsigned SHADOW_W = SEG_W - 8;

    localparam logic [7:0] PUSH_LEN    = 8'(SEG_W / 8);
    localparam logic [7:0] SPINDLE_LEN = 8'd3;
    localparam logic [7:0] COOLANT_LEN = 8'd1;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_GET_STATUS  = 8'h01;
    localparam logic [7:0] OP_PUSH_SEG    = 8'h10;
    localparam logic [7:0] OP_START       = 8'h20;
    localparam logic [7:0] OP_PAUSE       = 8'h21;
    localparam logic [7:0] OP_STOP        = 8'h22;
    localparam logic [7:0] OP_SET_SPINDLE = 8'h30;
    localparam logic [7:0] OP_SET_COOLANT = 8'h31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_COMMIT
    } state_t;

    state_t              state;
    logic [7:0]          op;
    logic [7:0]          byte_cnt;
    logic [SHADOW_W-1:0] shadow;
    logic                err_overflow;
    logic                err_unknown;

    logic [7:0]          payload_len;
    logic [SEG_W-1:0]    payload_full;
    logic [SEG_W-1:0]    seg_next;
    logic                byte_strobe;

    assign byte_strobe  = rx_valid && !spi_cs_n;
    // Shadow plus the byte being strobed: the complete MSB-first payload
    // stream at the moment the final byte arrives.
    assign payload_full = {shadow, rx_data};

    // Payload length for the opcode currently being assembled
    always_comb begin
        payload_len = 8'd1;
        case (op)
            OP_PUSH_SEG:    payload_len = PUSH_LEN;
            OP_SET_SPINDLE: payload_len = SPINDLE_LEN;
            OP_SET_COOLANT: payload_len = COOLANT_LEN;
            default:        payload_len = 8'd1;
        endcase
    end

    // Remap the MSB-first stream (pos[0] first, accel last) into the
    // packed segment layout (pos[0] lowest, accel highest).
    always_comb begin
        seg_next = '0;
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            seg_next[i*STEP_WIDTH +: STEP_WIDTH] =
                payload_full[SEG_W-1-i*STEP_WIDTH -: STEP_WIDTH];
        end
        for (int unsigned j = 0; j < 4; j++) begin
            seg_next[POS_BITS + j*VELOCITY_WIDTH +: VELOCITY_WIDTH] =
                payload_full[(4-j)*VELOCITY_WIDTH-1 -: VELOCITY_WIDTH];
        end
    end

    // Command FSM with all registered outputs and status byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op            <= '0;
            byte_cnt      <= '0;
            shadow        <= '0;
            err_overflow  <= 1'b0;
            err_unknown   <= 1'b0;
            tx_data       <= '0;
            seg_wr        <= 1'b0;
            seg_data      <= '0;
            fifo_flush    <= 1'b0;
            motion_enable <= 1'b0;
            spindle_en    <= 1'b0;
            spindle_dir   <= 1'b0;
            spindle_duty  <= '0;
            coolant_mist  <= 1'b0;
            coolant_flood <= 1'b0;
        end else begin
            seg_wr     <= 1'b0;
            fifo_flush <= 1'b0;
            tx_data    <= {err_overflow, err_unknown, fifo_full, |limit_hit,
                           step_busy, motion_enable, spindle_en,
                           coolant_flood | coolant_mist};

            case (state)
                ST_IDLE: begin
                    if (byte_strobe) begin
                        op       <= rx_data;
                        byte_cnt <= '0;
                        shadow   <= '0;
                        case (rx_data)
                            OP_NOP: ;
                            // Error sets only originate from opcodes/commits
                            // that cannot share this cycle, so set still wins.
                            OP_GET_STATUS: begin
                                err_overflow <= 1'b0;
                                err_unknown  <= 1'b0;
                            end
                            OP_PUSH_SEG, OP_SET_SPINDLE, OP_SET_COOLANT:
                                state <= ST_PAYLOAD;
                            OP_START: begin
                                if (!(|limit_hit))
                                    motion_enable <= 1'b1;
                            end
                            OP_PAUSE:
                                motion_enable <= 1'b0;
                            OP_STOP: begin
                                motion_enable <= 1'b0;
                                fifo_flush    <= 1'b1;
                            end
                            default:
                                err_unknown <= 1'b1;
                        endcase
                    end
                end

                ST_PAYLOAD: begin
                    if (spi_cs_n) begin
                        state    <= ST_IDLE;
                        byte_cnt <= '0;
                        shadow   <= '0;
                    end else if (rx_valid) begin
                        if (byte_cnt == payload_len - 8'd1) begin
                            // Outputs are registered on the final-byte edge so
                            // they are visible exactly during the COMMIT cycle.
                            state    <= ST_COMMIT;
                            byte_cnt <= '0;
                            shadow   <= '0;
                            case (op)
                                OP_PUSH_SEG: begin
                                    if (!fifo_full) begin
                                        seg_wr   <= 1'b1;
                                        seg_data <= seg_next;
                                    end else begin
                                        err_overflow <= 1'b1;
                                    end
                                end
                                OP_SET_SPINDLE: begin
                                    spindle_en   <= payload_full[16];
                                    spindle_dir  <= payload_full[17];
                                    spindle_duty <= payload_full[15:0];
                                end
                                OP_SET_COOLANT: begin
                                    coolant_mist  <= rx_data[0];
                                    coolant_flood <= rx_data[1];
                                end
                                default: ;
                            endcase
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            shadow   <= {shadow[SHADOW_W-9:0], rx_data};
                        end
                    end
                end

                ST_COMMIT:
                    state <= ST_IDLE;

                default:
                    state <= ST_IDLE;
            endcase

            // Limit override has the last word over any START this cycle
            if (|limit_hit)
                motion_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Directed self-checking bench for motion_cmd_sequencer.
module tb_motion_cmd_sequencer;

    localparam int unsigned SEG_W = 3*32 + 4*24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              spi_cs_n;
    logic [7:0]        tx_data;
    logic              seg_wr;
    logic [SEG_W-1:0]  seg_data;
    logic              fifo_full;
    logic              fifo_flush;
    logic              step_busy;
    logic [2:0]        limit_hit;
    logic              motion_enable;
    logic              spindle_en;
    logic              spindle_dir;
    logic              coolant_mist;
    logic              coolant_flood;
    logic [15:0]       spindle_duty;

    int n_cmp = 0;
    int n_err = 0;
    int seg_count = 0;
    int flush_count = 0;

    logic [7:0]       pkt [25];
    logic [SEG_W-1:0] exp_seg;

    motion_cmd_sequencer #(
        .NUM_AXES(3),
        .STEP_WIDTH(32),
        .VELOCITY_WIDTH(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .spi_cs_n(spi_cs_n),
        .tx_data(tx_data),
        .seg_wr(seg_wr),
        .seg_data(seg_data),
        .fifo_full(fifo_full),
        .fifo_flush(fifo_flush),
        .step_busy(step_busy),
        .limit_hit(limit_hit),
        .motion_enable(motion_enable),
        .spindle_en(spindle_en),
        .spindle_dir(spindle_dir),
        .coolant_mist(coolant_mist),
        .coolant_flood(coolant_flood),
        .spindle_duty(spindle_duty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seg_wr)     seg_count++;
        if (fifo_flush) flush_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe one byte; returns on the falling edge right after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) send_byte(pkt[i]);
    endtask

    initial begin
        pkt = '{8'h10,
                8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h02,
                8'h00, 8'h00, 8'h00, 8'h03,
                8'h00, 8'h01, 8'h00,
                8'h00, 8'h02, 8'h00,
                8'h00, 8'h00, 8'h80,
                8'h00, 8'h00, 8'h10};
        exp_seg = {24'h000010, 24'h000080, 24'h000200, 24'h000100,
                   32'h00000003, 32'h00000002, 32'h00000001};

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; spi_cs_n = 1'b1;
        fifo_full = 1'b0; step_busy = 1'b0; limit_hit = '0;
        tick(3);
        check("rst_tx", tx_data, 8'h00);
        check("rst_ctrl", {motion_enable, spindle_en, spindle_dir, spindle_duty,
                           coolant_mist, coolant_flood, seg_wr, fifo_flush}, '0);
        check("rst_seg", seg_data, '0);
        rst_n = 1'b1; spi_cs_n = 1'b0;
        tick(2);

        // Segment push accepted
        send_pkt(25);
        check("push_wr", seg_wr, 1'b1);
        check("push_data", seg_data, exp_seg);
        tick(1);
        check("push_wr_off", seg_wr, 1'b0);
        check("push_count", seg_count, 1);

        // Segment push while FIFO full -> overflow, then GET_STATUS clears
        fifo_full = 1'b1;
        send_pkt(25);
        check("full_nowr", seg_wr, 1'b0);
        tick(1);
        check("full_ovf", tx_data[7], 1'b1);
        check("full_count", seg_count, 1);
        fifo_full = 1'b0;
        send_byte(8'h01);
        check("gs_still", tx_data[7], 1'b1);
        tick(1);
        check("gs_clear", tx_data[7], 1'b0);

        // Spindle update
        send_byte(8'h30); send_byte(8'h03); send_byte(8'h80);
        check("spin_pre", {spindle_en, spindle_dir, spindle_duty}, 18'h0);
        send_byte(8'h00);
        check("spin_set", {spindle_en, spindle_dir, spindle_duty}, {2'b11, 16'h8000});

        // Abort mid-push (11th byte coincides with cs high), then START
        send_pkt(11);
        spi_cs_n = 1'b1;
        send_byte(pkt[11]);
        spi_cs_n = 1'b0;
        tick(1);
        send_byte(8'h20);
        check("abort_start", motion_enable, 1'b1);
        tick(1);
        check("abort_noerr", tx_data[7:6], 2'b00);
        check("abort_count", seg_count, 1);

        // Limit handling and STOP
        limit_hit = 3'b010;
        tick(1);
        check("lim_clear", motion_enable, 1'b0);
        send_byte(8'h20);
        check("lim_start", motion_enable, 1'b0);
        check("lim_status", tx_data[4], 1'b1);
        limit_hit = '0;
        send_byte(8'h20);
        check("start_ok", motion_enable, 1'b1);
        send_byte(8'h22);
        check("stop_me", motion_enable, 1'b0);
        check("stop_flush", fifo_flush, 1'b1);
        tick(1);
        check("flush_off", fifo_flush, 1'b0);
        check("flush_count", flush_count, 1);

        // Byte with cs high in IDLE is ignored
        spi_cs_n = 1'b1;
        send_byte(8'h20);
        spi_cs_n = 1'b0;
        tick(1);
        check("cs_ignore", motion_enable, 1'b0);

        // Unknown opcode, then coolant
        send_byte(8'h7F);
        tick(1);
        check("unk_err", tx_data[6], 1'b1);
        send_byte(8'h31); send_byte(8'h02);
        check("coolant", {coolant_flood, coolant_mist}, 2'b10);
        tick(1);
        check("cool_status", tx_data[0], 1'b1);
        send_byte(8'h01);
        tick(1);
        check("unk_clear", tx_data[6], 1'b0);

        // Reset mid-payload
        send_pkt(13);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {motion_enable, spindle_en, spindle_dir, spindle_duty,
                              coolant_mist, coolant_flood}, '0);
        check("midrst_tx", tx_data, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("midrst_count", seg_count, 1);
        check("midrst_seg", seg_data, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motion_cmd_sequencer.md
MOTION_CMD_SEQUENCER -- requirements
Module: motion_cmd_sequencer

Interface
REQ-001 Parameter NUM_AXES, 3, number of motion axes (1..6) SHALL be supported.
REQ-002 Parameter STEP_WIDTH, 32, position field width; SHALL be a multiple of 8.
REQ-003 Parameter VELOCITY_WIDTH, 24, velocity/acceleration field width; SHALL be a multiple of 8.
REQ-004 Port clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port rx_data  input  8  received SPI byte.
REQ-007 Port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 Port spi_cs_n  input  1  frame delimiter; high = no frame.
REQ-009 Port tx_data  output  8  registered status byte for the next SPI transfer.
REQ-010 Port seg_wr  output  1  one-cycle segment FIFO write strobe.
REQ-011 Port seg_data  output  NUM_AXES*STEP_WIDTH+4*VELOCITY_WIDTH  packed segment: target_pos[i] at [i*STEP_WIDTH +: STEP_WIDTH], then entry, cruise, exit, accel in ascending order above the positions.
REQ-012 Port fifo_full  input  1  segment FIFO full.
REQ-013 Port fifo_flush  output  1  one-cycle FIFO clear strobe.
REQ-014 Port step_busy  input  1  step generator active.
REQ-015 Port limit_hit  input  NUM_AXES  per-axis limit active.
REQ-016 Ports motion_enable, spindle_en, spindle_dir, coolant_mist, coolant_flood  output  1 each  registered control levels.
REQ-017 Port spindle_duty  output  16  registered PWM duty.

Function
REQ-018 Opcodes SHALL be: 0x00 NOP, 0x01 GET_STATUS, 0x10 PUSH_SEG, 0x20 START, 0x21 PAUSE, 0x22 STOP, 0x30 SET_SPINDLE, 0x31 SET_COOLANT.
REQ-019 FSM states SHALL be IDLE, PAYLOAD, COMMIT; the first byte accepted in IDLE is the opcode.
REQ-020 Payload lengths: PUSH_SEG = NUM_AXES*STEP_WIDTH/8 + 4*VELOCITY_WIDTH/8 (24 at defaults), SET_SPINDLE = 3, SET_COOLANT = 1, all others = 0 (execute in the cycle after the opcode strobe; FSM stays IDLE).
REQ-021 Multi-byte fields SHALL be MSB-first; PUSH_SEG field order SHALL be target_pos[0..NUM_AXES-1], entry, cruise, exit, accel.
REQ-022 Payload SHALL be assembled into shadow registers; outputs change only in COMMIT, one cycle after the final payload byte strobe; COMMIT returns to IDLE after one cycle.
REQ-023 PUSH_SEG COMMIT: if fifo_full=0, seg_wr=1 for exactly one cycle with seg_data valid on that cycle; if fifo_full=1, no write, err_overflow sticky set.
REQ-024 SET_SPINDLE payload: byte0 bit0=en, bit1=dir; bytes1-2 = duty MSB, LSB; all three outputs SHALL update in the same cycle.
REQ-025 SET_COOLANT payload: bit0=mist, bit1=flood.
REQ-026 START SHALL set motion_enable unless |limit_hit=1, in which case it is ignored.
REQ-027 PAUSE SHALL clear motion_enable; STOP SHALL clear motion_enable and pulse fifo_flush for one cycle.
REQ-028 Any cycle with |limit_hit=1 SHALL clear motion_enable, overriding a simultaneous START.
REQ-029 An unknown opcode SHALL set err_unknown sticky and leave the FSM in IDLE.
REQ-030 spi_cs_n high in PAYLOAD SHALL abort to IDLE, discard shadow data, and raise no error; if spi_cs_n=1 coincides with rx_valid, the byte SHALL be discarded.
REQ-031 rx_valid with spi_cs_n=1 in IDLE SHALL be ignored.
REQ-032 tx_data SHALL be updated every cycle as {err_overflow, err_unknown, fifo_full, |limit_hit, step_busy, motion_enable, spindle_en, coolant_flood|coolant_mist}, MSB first.
REQ-033 GET_STATUS SHALL clear both sticky errors one cycle after its opcode strobe; an error raised in the same cycle SHALL win over the clear.

Reset
REQ-034 While rst_n=0: FSM=IDLE, byte counter=0, shadow registers=0, seg_wr=0, fifo_flush=0, seg_data=0, motion_enable=0, spindle_en=0, spindle_dir=0, spindle_duty=0, coolant_mist=0, coolant_flood=0, sticky errors=0, tx_data=0x00.
REQ-035 Reset asserted mid-payload SHALL discard the partial command; no seg_wr SHALL follow deassertion.

Verification
REQ-036 PUSH_SEG with pos 0x00000001/0x00000002/0x00000003, velocities 0x000100/0x000200/0x000080, accel 0x000010, fifo_full=0 -> one seg_wr pulse one cycle after byte 24, fields packed per REQ-011.
REQ-037 Same packet with fifo_full=1 -> no seg_wr; tx_data bit7=1; GET_STATUS then clears it, so tx_data bit7=0 two cycles later.
REQ-038 0x30,0x03,0x80,0x00 -> spindle_en=1, spindle_dir=1, spindle_duty=0x8000, all in the same cycle.
REQ-039 PUSH_SEG aborted by spi_cs_n after 10 bytes, then 0x20 -> no seg_wr, no error, motion_enable=1.
REQ-040 START with limit_hit=3'b010 -> motion_enable stays 0; START after the limit clears -> 1; then STOP -> motion_enable=0 with one fifo_flush pulse.
REQ-041 Opcode 0x7F -> tx_data bit6=1, FSM in IDLE; a following 0x31,0x02 -> coolant_flood=1, coolant_mist=0.
